// File: rtl/i2c_reg_target.sv
// I2C target exposing a small byte-wide register file with an auto-incrementing pointer.
// The bus is oversampled on i_clk; all protocol decisions use synchronized SCL/SDA edges.
module i2c_reg_target #(
    parameter logic [6:0] DEVICE_ADDR = 7'h11,
    parameter int         NUM_REGS    = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_scl,
    input  logic       i_sda,
    output logic       o_sda_oe,
    output logic       o_busy,
    output logic       o_wr_valid,
    output logic [7:0] o_wr_addr,
    output logic [7:0] o_wr_data
);

    localparam int IDX_W = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1;

    typedef enum logic [3:0] {
        IDLE,
        DEV_ADDR,
        DEV_ACK,
        REG_ADDR,
        REG_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_ACK,
        IGNORE
    } state_t;

    logic [1:0] scl_sync_q;
    logic [1:0] sda_sync_q;
    logic       scl_prev_q;
    logic       sda_prev_q;

    state_t     state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] ptr_q, ptr_d;
    logic       sda_oe_q, sda_oe_d;
    logic       busy_q, busy_d;
    logic       wr_valid_q, wr_valid_d;
    logic [7:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;

    logic [7:0] regfile_q [NUM_REGS];
    logic       rf_we;
    logic [7:0] rf_wdata;

    logic             scl_s, sda_s;
    logic             scl_rise, scl_fall, start_det, stop_det;
    logic [IDX_W-1:0] rf_idx;
    logic [7:0]       rf_rdata;
    logic [7:0]       shift_in;

    // Synchronizers reset to 1 so a reset looks like an idle bus.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], i_scl};
            sda_sync_q <= {sda_sync_q[0], i_sda};
            scl_prev_q <= scl_sync_q[1];
            sda_prev_q <= sda_sync_q[1];
        end
    end

    assign scl_s     = scl_sync_q[1];
    assign sda_s     = sda_sync_q[1];
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

    assign rf_idx   = ptr_q[IDX_W-1:0];
    assign rf_rdata = regfile_q[rf_idx];
    assign shift_in = {shift_q[6:0], sda_s};

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        ptr_d      = ptr_q;
        sda_oe_d   = sda_oe_q;
        busy_d     = busy_q;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        rf_we      = 1'b0;
        rf_wdata   = shift_in;

        // START/STOP override everything and drop any partially received byte.
        if (start_det) begin
            state_d   = DEV_ADDR;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else if (stop_det) begin
            state_d   = IDLE;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                DEV_ADDR: begin
                    if (scl_rise) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        if (shift_q[7:1] == DEVICE_ADDR) begin
                            state_d  = DEV_ACK;
                            sda_oe_d = 1'b1;
                            busy_d   = 1'b1;
                        end else begin
                            state_d = IGNORE;
                        end
                    end
                end
                DEV_ACK: begin
                    // shift_q[0] still holds the R/W bit of the address byte.
                    if (scl_fall) begin
                        bit_cnt_d = 4'd0;
                        if (shift_q[0]) begin
                            state_d  = RDATA;
                            shift_d  = rf_rdata;
                            sda_oe_d = ~rf_rdata[7];
                        end else begin
                            state_d  = REG_ADDR;
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                REG_ADDR: begin
                    if (scl_rise) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        ptr_d    = shift_q;
                        sda_oe_d = 1'b1;
                        state_d  = REG_ACK;
                    end
                end
                REG_ACK, WDATA_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 4'd0;
                        state_d   = WDATA;
                    end
                end
                WDATA: begin
                    if (scl_rise) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            rf_we      = 1'b1;
                            wr_valid_d = 1'b1;
                            wr_addr_d  = ptr_q;
                            wr_data_d  = shift_in;
                            ptr_d      = ptr_q + 8'd1;
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        sda_oe_d = 1'b1;
                        state_d  = WDATA_ACK;
                    end
                end
                RDATA: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d = 1'b0;
                            ptr_d    = ptr_q + 8'd1;
                            state_d  = RDATA_ACK;
                        end else begin
                            shift_d  = {shift_q[6:0], 1'b0};
                            sda_oe_d = ~shift_q[6];
                        end
                    end
                end
                RDATA_ACK: begin
                    if (scl_rise) begin
                        shift_d = shift_in;
                    end else if (scl_fall) begin
                        if (!shift_q[0]) begin
                            state_d   = RDATA;
                            bit_cnt_d = 4'd0;
                            shift_d   = rf_rdata;
                            sda_oe_d  = ~rf_rdata[7];
                        end else begin
                            state_d = IGNORE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= 4'd0;
            shift_q    <= 8'd0;
            ptr_q      <= 8'd0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= 8'd0;
            wr_data_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            ptr_q      <= ptr_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regfile_q[i] <= 8'd0;
            end
        end else if (rf_we) begin
            regfile_q[rf_idx] <= rf_wdata;
        end
    end

    assign o_sda_oe   = sda_oe_q;
    assign o_busy     = busy_q;
    assign o_wr_valid = wr_valid_q;
    assign o_wr_addr  = wr_addr_q;
    assign o_wr_data  = wr_data_q;

endmodule

// File: tb/tb_i2c_reg_target.sv
// Bit-banged I2C master driving i2c_reg_target, checked against an array model of the registers.
module tb_i2c_reg_target;

    localparam int         NUM_REGS = 4;
    localparam logic [6:0] DEV      = 7'h11;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       m_scl;
    logic       m_sda;
    logic       bus_sda;
    logic       o_sda_oe;
    logic       o_busy;
    logic       o_wr_valid;
    logic [7:0] o_wr_addr;
    logic [7:0] o_wr_data;

    assign bus_sda = m_sda & ~o_sda_oe;

    i2c_reg_target #(.DEVICE_ADDR(DEV), .NUM_REGS(NUM_REGS)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_scl      (m_scl),
        .i_sda      (bus_sda),
        .o_sda_oe   (o_sda_oe),
        .o_busy     (o_busy),
        .o_wr_valid (o_wr_valid),
        .o_wr_addr  (o_wr_addr),
        .o_wr_data  (o_wr_data)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] wq_addr[$];
    logic [7:0] wq_data[$];
    logic       oe_seen = 1'b0;

    logic [7:0] model_rf [NUM_REGS];
    logic [7:0] model_ptr;
    logic [7:0] wbuf [8];
    logic [7:0] rbuf [8];

    always @(posedge i_clk) begin
        if (o_wr_valid === 1'b1) begin
            wq_addr.push_back(o_wr_addr);
            wq_data.push_back(o_wr_data);
        end
        if (o_sda_oe === 1'b1) oe_seen = 1'b1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    // One SCL period, entered and left with SCL low; s is SDA seen mid high phase.
    task automatic bus_bit(input logic b, output logic s);
        tick(2);
        m_sda = b;
        tick(6);
        m_scl = 1'b1;
        tick(4);
        s = bus_sda;
        tick(4);
        m_scl = 1'b0;
    endtask

    task automatic bus_start();
        m_sda = 1'b1;
        tick(4);
        m_scl = 1'b1;
        tick(4);
        m_sda = 1'b0;
        tick(4);
        m_scl = 1'b0;
    endtask

    task automatic bus_stop();
        tick(2);
        m_sda = 1'b0;
        tick(4);
        m_scl = 1'b1;
        tick(4);
        m_sda = 1'b1;
        tick(4);
    endtask

    task automatic send_byte(input logic [7:0] tx, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bus_bit(tx[i], s);
        bus_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic recv_byte(input logic m_ack, output logic [7:0] rx);
        logic s;
        rx = 8'h00;
        for (int i = 0; i < 8; i++) begin
            bus_bit(1'b1, s);
            rx = {rx[6:0], s};
        end
        bus_bit(m_ack ? 1'b0 : 1'b1, s);
    endtask

    task automatic wr_txn(input logic [7:0] p, input int n, output int acks);
        logic a;
        acks = 0;
        bus_start();
        send_byte({DEV, 1'b0}, a); acks += int'(a);
        send_byte(p, a);           acks += int'(a);
        for (int k = 0; k < n; k++) begin
            send_byte(wbuf[k], a); acks += int'(a);
        end
        bus_stop();
        tick(4);
    endtask

    task automatic rd_txn(input logic [7:0] p, input logic set_ptr, input int n, output int acks);
        logic a;
        acks = 0;
        bus_start();
        if (set_ptr) begin
            send_byte({DEV, 1'b0}, a); acks += int'(a);
            send_byte(p, a);           acks += int'(a);
            bus_start();
        end
        send_byte({DEV, 1'b1}, a); acks += int'(a);
        for (int k = 0; k < n; k++) recv_byte(k != n - 1, rbuf[k]);
        bus_stop();
        tick(4);
    endtask

    function automatic void model_write(input logic [7:0] p, input int n);
        for (int k = 0; k < n; k++) model_rf[int'(8'(p + 8'(k))) % NUM_REGS] = wbuf[k];
        model_ptr = 8'(p + 8'(n));
    endfunction

    task automatic test_reset();
        i_rst = 1'b0;
        tick(2);
        i_rst = 1'b1;
        tick(3);
        checks++; if (o_sda_oe !== 1'b0) begin errors++; $display("FAIL reset_oe got %b expected 0", o_sda_oe); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", o_busy); end
        checks++; if (o_wr_valid !== 1'b0) begin errors++; $display("FAIL reset_wr_valid got %b expected 0", o_wr_valid); end
        checks++; if (o_wr_addr !== 8'h00) begin errors++; $display("FAIL reset_wr_addr got %h expected 00", o_wr_addr); end
        checks++; if (o_wr_data !== 8'h00) begin errors++; $display("FAIL reset_wr_data got %h expected 00", o_wr_data); end
        i_rst = 1'b0;
        tick(4);
        for (int i = 0; i < NUM_REGS; i++) model_rf[i] = 8'h00;
        model_ptr = 8'h00;
        $display("reset done");
    endtask

    task automatic test_write_basic();
        logic a;
        int   acks = 0;
        wq_addr.delete(); wq_data.delete();
        bus_start();
        send_byte({DEV, 1'b0}, a); acks += int'(a);
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL busy_after_match got %b expected 1", o_busy); end
        send_byte(8'h00, a); acks += int'(a);
        send_byte(8'hDC, a); acks += int'(a);
        bus_stop();
        tick(4);
        checks++; if (acks !== 3) begin errors++; $display("FAIL basic_acks got %0d expected 3", acks); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL busy_after_stop got %b expected 0", o_busy); end
        checks++;
        if (wq_addr.size() !== 1) begin
            errors++; $display("FAIL basic_wr_count got %0d expected 1", wq_addr.size());
        end else if (wq_addr[0] !== 8'h00 || wq_data[0] !== 8'hDC) begin
            errors++; $display("FAIL basic_wr_event got %h/%h expected 00/dc", wq_addr[0], wq_data[0]);
        end
        wbuf[0] = 8'hDC;
        model_write(8'h00, 1);
        $display("write reg 00 data dc acks %0d", acks);
    endtask

    task automatic test_read_back();
        int acks;
        rd_txn(8'h00, 1'b1, 1, acks);
        checks++; if (acks !== 3) begin errors++; $display("FAIL readback_acks got %0d expected 3", acks); end
        checks++; if (rbuf[0] !== 8'hDC) begin errors++; $display("FAIL readback_data got %h expected dc", rbuf[0]); end
        model_ptr = 8'h01;
        $display("read reg 00 data %h", rbuf[0]);
    endtask

    task automatic test_wrong_addr();
        logic a;
        oe_seen = 1'b0;
        bus_start();
        send_byte({7'h12, 1'b0}, a);
        checks++; if (a !== 1'b0) begin errors++; $display("FAIL wrong_addr_ack got %b expected 0", a); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL wrong_addr_busy got %b expected 0", o_busy); end
        send_byte(8'h00, a);
        bus_stop();
        tick(4);
        checks++; if (oe_seen !== 1'b0) begin errors++; $display("FAIL wrong_addr_oe got %b expected 0", oe_seen); end
        $display("address 12 ignored");
    endtask

    task automatic test_burst();
        int acks;
        wq_addr.delete(); wq_data.delete();
        wbuf[0] = 8'hA1; wbuf[1] = 8'hB2;
        wr_txn(8'h03, 2, acks);
        model_write(8'h03, 2);
        checks++; if (acks !== 4) begin errors++; $display("FAIL burst_acks got %0d expected 4", acks); end
        checks++;
        if (wq_addr.size() !== 2) begin
            errors++; $display("FAIL burst_wr_count got %0d expected 2", wq_addr.size());
        end else if (wq_addr[0] !== 8'h03 || wq_data[0] !== 8'hA1 || wq_addr[1] !== 8'h04 || wq_data[1] !== 8'hB2) begin
            errors++; $display("FAIL burst_wr_events got %h/%h %h/%h expected 03/a1 04/b2",
                               wq_addr[0], wq_data[0], wq_addr[1], wq_data[1]);
        end
        rd_txn(8'h03, 1'b1, 2, acks);
        model_ptr = 8'h05;
        checks++; if (rbuf[0] !== 8'hA1) begin errors++; $display("FAIL burst_reg3 got %h expected a1", rbuf[0]); end
        checks++; if (rbuf[1] !== 8'hB2) begin errors++; $display("FAIL burst_reg0 got %h expected b2", rbuf[1]); end
        $display("burst reg 03 wrote a1 b2 read %h %h", rbuf[0], rbuf[1]);
    endtask

    task automatic test_random();
        int         acks, n, n2;
        logic [7:0] p, p2, exp;
        logic       set_ptr;
        for (int it = 0; it < 5; it++) begin
            p = 8'($urandom);
            n = int'($urandom_range(1, 4));
            for (int k = 0; k < n; k++) wbuf[k] = 8'($urandom);
            wq_addr.delete(); wq_data.delete();
            wr_txn(p, n, acks);
            checks++; if (acks !== n + 2) begin errors++; $display("FAIL rand_wr_acks got %0d expected %0d", acks, n + 2); end
            checks++;
            if (wq_addr.size() !== n) begin
                errors++; $display("FAIL rand_wr_count got %0d expected %0d", wq_addr.size(), n);
            end else begin
                for (int k = 0; k < n; k++) begin
                    if (wq_addr[k] !== 8'(p + 8'(k)) || wq_data[k] !== wbuf[k]) begin
                        errors++; $display("FAIL rand_wr_event got %h/%h expected %h/%h",
                                           wq_addr[k], wq_data[k], 8'(p + 8'(k)), wbuf[k]);
                    end
                end
            end
            model_write(p, n);
            set_ptr = 1'($urandom_range(0, 1));
            p2 = set_ptr ? 8'($urandom) : model_ptr;
            n2 = int'($urandom_range(1, 4));
            rd_txn(p2, set_ptr, n2, acks);
            for (int k = 0; k < n2; k++) begin
                exp = model_rf[int'(8'(p2 + 8'(k))) % NUM_REGS];
                checks++;
                if (rbuf[k] !== exp) begin
                    errors++; $display("FAIL rand_rd_data ptr %h got %h expected %h", 8'(p2 + 8'(k)), rbuf[k], exp);
                end
            end
            model_ptr = 8'(p2 + 8'(n2));
            $display("random write ptr %h len %0d, read ptr %h len %0d", p, n, p2, n2);
        end
    endtask

    task automatic test_abort();
        logic       a, s;
        int         acks;
        logic [7:0] rx;
        wq_addr.delete(); wq_data.delete();
        bus_start();
        send_byte({DEV, 1'b0}, a);
        send_byte(8'h01, a);
        bus_bit(1'b1, s); bus_bit(1'b0, s); bus_bit(1'b1, s); bus_bit(1'b0, s);
        bus_stop();
        tick(4);
        model_ptr = 8'h01;
        checks++; if (wq_addr.size() !== 0) begin errors++; $display("FAIL abort_no_write got %0d expected 0", wq_addr.size()); end
        checks++; if (o_sda_oe !== 1'b0) begin errors++; $display("FAIL abort_oe got %b expected 0", o_sda_oe); end
        rd_txn(8'h00, 1'b0, 1, acks);
        checks++; if (rbuf[0] !== model_rf[1]) begin errors++; $display("FAIL abort_reg_kept got %h expected %h", rbuf[0], model_rf[1]); end
        $display("stop after 4 bits, reg 01 %h", rbuf[0]);

        // Reset in the middle of the master ACK slot of a read.
        bus_start();
        send_byte({DEV, 1'b0}, a);
        send_byte(8'h00, a);
        bus_start();
        send_byte({DEV, 1'b1}, a);
        for (int i = 0; i < 8; i++) bus_bit(1'b1, s);
        tick(2);
        m_sda = 1'b0;
        tick(6);
        m_scl = 1'b1;
        tick(2);
        i_rst = 1'b1;
        tick(1);
        checks++; if (o_sda_oe !== 1'b0) begin errors++; $display("FAIL rst_oe got %b expected 0", o_sda_oe); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b expected 0", o_busy); end
        m_scl = 1'b0;
        m_sda = 1'b1;
        tick(4);
        i_rst = 1'b0;
        tick(4);
        for (int i = 0; i < NUM_REGS; i++) model_rf[i] = 8'h00;
        model_ptr = 8'h00;

        oe_seen = 1'b0;
        send_byte({DEV, 1'b0}, a);
        checks++; if (oe_seen !== 1'b0) begin errors++; $display("FAIL rst_ignore_oe got %b expected 0", oe_seen); end
        bus_stop();
        tick(4);
        rd_txn(8'h00, 1'b0, NUM_REGS, acks);
        for (int k = 0; k < NUM_REGS; k++) begin
            checks++;
            if (rbuf[k] !== model_rf[k]) begin errors++; $display("FAIL rst_regfile reg %0d got %h expected %h", k, rbuf[k], model_rf[k]); end
        end
        model_ptr = 8'(NUM_REGS);

        rx = 8'($urandom);
        wbuf[0] = rx;
        wq_addr.delete(); wq_data.delete();
        wr_txn(8'h02, 1, acks);
        model_write(8'h02, 1);
        checks++; if (acks !== 3) begin errors++; $display("FAIL post_rst_acks got %0d expected 3", acks); end
        checks++; if (wq_addr.size() !== 1) begin errors++; $display("FAIL post_rst_wr_count got %0d expected 1", wq_addr.size()); end
        rd_txn(8'h02, 1'b1, 1, acks);
        checks++; if (rbuf[0] !== model_rf[2]) begin errors++; $display("FAIL post_rst_read got %h expected %h", rbuf[0], model_rf[2]); end
        $display("reset during read ack, then wrote/read reg 02 %h", rbuf[0]);
    endtask

    initial begin
        m_scl = 1'b1;
        m_sda = 1'b1;
        i_rst = 1'b1;
        test_reset();
        test_write_basic();
        test_read_back();
        test_wrong_addr();
        test_burst();
        test_random();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
